// File: rtl/pipe_hazard_unit_if.sv
// ID-stage side of the hazard/forwarding controller: decoded operand and
// destination info plus branch redirect going in, stall/flush/forward selects
// and event counters coming back.
interface pipe_hazard_unit_if #(
  parameter int STAGES = 4,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 16
);
  localparam int FWD_W = $clog2(STAGES + 1);

  logic             en;
  logic             id_valid;
  logic [REG_W-1:0] id_ra;
  logic [REG_W-1:0] id_rb;
  logic             id_use_ra;
  logic             id_use_rb;
  logic             id_wr_en;
  logic [REG_W-1:0] id_wr_reg;
  logic             id_load;
  logic             br_taken;

  logic             stall;
  logic             flush;
  logic [FWD_W-1:0] fwd_a;
  logic [FWD_W-1:0] fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline control side: drives the decoded instruction, consumes controls.
  modport master (
    output en, id_valid, id_ra, id_rb, id_use_ra, id_use_rb,
           id_wr_en, id_wr_reg, id_load, br_taken,
    input  stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  // Hazard unit side.
  modport slave (
    input  en, id_valid, id_ra, id_rb, id_use_ra, id_use_rb,
           id_wr_en, id_wr_reg, id_load, br_taken,
    output stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and forwarding controller. Keeps a shadow pipeline of
// destination tags for every instruction between ID and write-back and derives
// stall, flush and per-operand forwarding selects from it.
module pipe_hazard_unit #(
  parameter int STAGES     = 4,
  parameter int REG_W      = 3,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 3,
  parameter int BR_STAGE   = 2,
  parameter int CNT_W      = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_unit_if.slave hz
);
  localparam int FWD_W = $clog2(STAGES + 1);

  typedef struct packed {
    logic             valid;
    logic             wr_en;
    logic [REG_W-1:0] wr_reg;
    logic             load;
  } entry_t;

  typedef struct packed {
    logic             hazard;
    logic [FWD_W-1:0] fwd;
  } fwd_res_t;

  entry_t           shadow_q [1:STAGES];
  entry_t           shadow_d [1:STAGES];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  fwd_res_t res_a, res_b;
  logic     stall_c, flush_c;

  // Youngest matching writer wins: scan oldest-to-youngest so the lowest
  // stage overwrites. Stage STAGES is writing the register file right now and
  // the file has no bypass, so it is forwarded like any other ready stage.
  function automatic fwd_res_t resolve(input logic [REG_W-1:0] rx,
                                       input logic             use_rx);
    fwd_res_t r;
    int       hit_k;
    logic     hit_ld;
    r      = '0;
    hit_k  = 0;
    hit_ld = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (shadow_q[k].valid && shadow_q[k].wr_en && shadow_q[k].wr_reg == rx) begin
        hit_k  = k;
        hit_ld = shadow_q[k].load;
      end
    end
    if (use_rx && hit_k != 0) begin
      if (hit_k >= (hit_ld ? LOAD_READY : ALU_READY)) r.fwd = FWD_W'(hit_k);
      else                                            r.hazard = 1'b1;
    end
    return r;
  endfunction

  // Same-cycle controls; a taken branch overrides any stall.
  always_comb begin
    res_a   = resolve(hz.id_ra, hz.en & hz.id_valid & hz.id_use_ra);
    res_b   = resolve(hz.id_rb, hz.en & hz.id_valid & hz.id_use_rb);
    stall_c = hz.en & hz.id_valid & (res_a.hazard | res_b.hazard) & ~hz.br_taken;
    flush_c = hz.en & hz.br_taken;
  end

  assign hz.stall     = stall_c;
  assign hz.flush     = flush_c;
  assign hz.fwd_a     = res_a.fwd;
  assign hz.fwd_b     = res_b.fwd;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

  // Shadow pipeline advance: ID enters stage 1 (bubble on stall/flush), older
  // entries shift; a taken branch squashes the wrong-path entries younger than it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    shadow_d = shadow_q;
    if (hz.en) begin
      shadow_d[1].valid  = hz.id_valid & ~stall_c & ~flush_c;
      shadow_d[1].wr_en  = hz.id_wr_en;
      shadow_d[1].wr_reg = hz.id_wr_reg;
      shadow_d[1].load   = hz.id_load;
      for (int k = 2; k <= STAGES; k++) begin
        shadow_d[k] = shadow_q[k-1];
        if (flush_c && (k - 1) < BR_STAGE) shadow_d[k].valid = 1'b0;
      end
    end
  end

  // Saturating event counters; stall_c/flush_c already carry the enable.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_c && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_c && flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // State registers with synchronous reset that overrides enable and branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shadow array is a handful of flops, not a RAM, so every entry is reset explicitly.
      for (int k = 1; k <= STAGES; k++) shadow_q[k] <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers sample pre-edge values together.
      shadow_q    <= shadow_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: table of per-cycle vectors with
// expected controls routed through a scoreboard queue, plus hand sequences for
// counters, reset and saturation. A second instance with CNT_W=2 sees the
// same stimulus to exercise counter saturation.
module tb_pipe_hazard_unit;
  localparam int STAGES = 4;
  localparam int REG_W  = 3;
  localparam int FWD_W  = $clog2(STAGES + 1);

  typedef struct {
    logic             en, valid;
    logic [REG_W-1:0] ra;
    logic             ua;
    logic [REG_W-1:0] rb;
    logic             ub, we;
    logic [REG_W-1:0] wr;
    logic             ld, br;
    logic             stall, flush;
    logic [FWD_W-1:0] fa, fb;
  } vec_t;

  typedef struct {
    logic             stall, flush;
    logic [FWD_W-1:0] fa, fb;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic en, id_valid, id_use_ra, id_use_rb, id_wr_en, id_load, br_taken;
  logic [REG_W-1:0] id_ra, id_rb, id_wr_reg;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  exp_t sb_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipe_hazard_unit_if #(.STAGES(STAGES), .REG_W(REG_W), .CNT_W(16)) bus ();
  pipe_hazard_unit_if #(.STAGES(STAGES), .REG_W(REG_W), .CNT_W(2))  bus_sat ();

  assign bus.en        = en;        assign bus_sat.en        = en;
  assign bus.id_valid  = id_valid;  assign bus_sat.id_valid  = id_valid;
  assign bus.id_ra     = id_ra;     assign bus_sat.id_ra     = id_ra;
  assign bus.id_rb     = id_rb;     assign bus_sat.id_rb     = id_rb;
  assign bus.id_use_ra = id_use_ra; assign bus_sat.id_use_ra = id_use_ra;
  assign bus.id_use_rb = id_use_rb; assign bus_sat.id_use_rb = id_use_rb;
  assign bus.id_wr_en  = id_wr_en;  assign bus_sat.id_wr_en  = id_wr_en;
  assign bus.id_wr_reg = id_wr_reg; assign bus_sat.id_wr_reg = id_wr_reg;
  assign bus.id_load   = id_load;   assign bus_sat.id_load   = id_load;
  assign bus.br_taken  = br_taken;  assign bus_sat.br_taken  = br_taken;

  pipe_hazard_unit #(.STAGES(STAGES), .REG_W(REG_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .hz(bus)
  );

  pipe_hazard_unit #(.STAGES(STAGES), .REG_W(REG_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .hz(bus_sat)
  );

  function automatic vec_t mk(int e, int v, int ra, int ua, int rb, int ub, int we,
                              int wr, int ld, int br, int s, int f, int fa, int fb);
    vec_t r;
    r.en = 1'(e);   r.valid = 1'(v);  r.ra = REG_W'(ra); r.ua = 1'(ua);
    r.rb = REG_W'(rb); r.ub = 1'(ub); r.we = 1'(we);     r.wr = REG_W'(wr);
    r.ld = 1'(ld);  r.br = 1'(br);    r.stall = 1'(s);   r.flush = 1'(f);
    r.fa = FWD_W'(fa); r.fb = FWD_W'(fb);
    return r;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Drive one ID cycle at the falling edge, push the expectation, compare
  // before the rising edge, then advance to the next falling edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    en = v.en; id_valid = v.valid; id_ra = v.ra; id_use_ra = v.ua;
    id_rb = v.rb; id_use_rb = v.ub; id_wr_en = v.we; id_wr_reg = v.wr;
    id_load = v.ld; br_taken = v.br;
    sb_q.push_back('{v.stall, v.flush, v.fa, v.fb});
    #2;
    e = sb_q.pop_front();
    vec_cnt++;
    if (bus.stall !== e.stall || bus.flush !== e.flush ||
        bus.fwd_a !== e.fa || bus.fwd_b !== e.fb) begin
      err_cnt++;
      $display("FAIL %s: stall/flush/fwd_a/fwd_b got %b/%b/%0d/%0d expected %b/%b/%0d/%0d",
               tag, bus.stall, bus.flush, bus.fwd_a, bus.fwd_b,
               e.stall, e.flush, e.fa, e.fb);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // mk(en,valid,ra,use_a,rb,use_b,wr_en,wr_reg,load,br, stall,flush,fwd_a,fwd_b)
    tbl.push_back(mk(1,1,1,1,2,1,0,0,0,0, 0,0,0,0)); // after reset: nothing in flight
    tbl.push_back(mk(1,1,0,0,0,0,1,1,0,0, 0,0,0,0)); // ADD r1
    tbl.push_back(mk(1,1,1,1,5,1,1,4,0,0, 0,0,1,0)); // SUB uses r1 -> stage 1, writes r4
    tbl.push_back(mk(1,1,1,1,4,1,0,0,0,0, 0,0,2,1));
    tbl.push_back(mk(1,1,1,1,4,1,0,0,0,0, 0,0,3,2));
    tbl.push_back(mk(1,1,1,1,4,1,0,0,0,0, 0,0,4,3)); // r1 in write-back stage
    tbl.push_back(mk(1,1,1,1,4,1,0,0,0,0, 0,0,0,4)); // r1 retired
    tbl.push_back(mk(1,1,4,1,0,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,1,2,1,0, 0,0,0,0)); // LD r2
    tbl.push_back(mk(1,1,2,1,6,1,1,6,0,0, 1,0,0,0)); // load-use, producer stage 1
    tbl.push_back(mk(1,1,2,1,6,1,1,6,0,0, 1,0,0,0)); // producer stage 2; stalled r6 never entered
    tbl.push_back(mk(1,1,2,1,6,1,1,6,0,0, 0,0,3,0)); // producer at LOAD_READY
    tbl.push_back(mk(1,1,6,1,2,1,0,0,0,0, 0,0,1,4));
    tbl.push_back(mk(1,1,0,0,0,0,1,3,1,0, 0,0,0,0)); // LD r3
    tbl.push_back(mk(1,1,0,0,0,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,1,3,0,0, 0,0,0,0)); // ADD r3
    tbl.push_back(mk(1,1,3,1,3,1,0,0,0,0, 0,0,1,1)); // youngest r3 writer wins
    tbl.push_back(mk(1,1,0,0,0,0,1,2,1,0, 0,0,0,0)); // LD r2 (younger than the branch)

    en = 1'b0; id_valid = 1'b0; id_ra = '0; id_rb = '0; id_use_ra = 1'b0;
    id_use_rb = 1'b0; id_wr_en = 1'b0; id_wr_reg = '0; id_load = 1'b0; br_taken = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset_stall_cnt", int'(bus.stall_cnt), 0);
    check("reset_flush_cnt", int'(bus.flush_cnt), 0);
    foreach (tbl[i]) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
      if (i == 11) check("stall_cnt_after_load_use", int'(bus.stall_cnt), 2);
    end

    // Branch while a load-use stall is pending: flush wins, LD r2 squashed.
    apply(mk(1,1,2,1,0,0,1,7,0,1, 0,1,0,0), "branch_over_stall");
    apply(mk(1,1,2,1,3,1,0,0,0,0, 0,0,0,4), "after_branch");
    check("flush_cnt_branch", int'(bus.flush_cnt), 1);
    check("stall_cnt_branch", int'(bus.stall_cnt), 2);

    // Freeze with a pending hazard, including a branch that must be ignored.
    apply(mk(1,1,0,0,0,0,1,5,1,0, 0,0,0,0), "ld_r5");
    for (int i = 0; i < 5; i++)
      apply(mk(0,1,5,1,0,0,0,0,0,(i == 2) ? 1 : 0, 0,0,0,0), $sformatf("frozen%0d", i));
    check("frozen_stall_cnt", int'(bus.stall_cnt), 2);
    check("frozen_flush_cnt", int'(bus.flush_cnt), 1);
    apply(mk(1,1,5,1,0,0,0,0,0,0, 1,0,0,0), "resume0");
    apply(mk(1,1,5,1,0,0,0,0,0,0, 1,0,0,0), "resume1");
    apply(mk(1,1,5,1,0,0,0,0,0,0, 0,0,3,0), "resume2");
    check("resume_stall_cnt", int'(bus.stall_cnt), 4);
    check("sat_stall_cnt_4", int'(bus_sat.stall_cnt), 3);

    // Reset in the middle of a stall releases it on the next cycle.
    apply(mk(1,1,0,0,0,0,1,7,1,0, 0,0,0,0), "ld_r7");
    apply(mk(1,1,7,1,0,0,0,0,0,0, 1,0,0,0), "stall_r7");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midstall_rst_stall_cnt", int'(bus.stall_cnt), 0);
    check("midstall_rst_flush_cnt", int'(bus.flush_cnt), 0);
    apply(mk(1,1,7,1,7,1,0,0,0,0, 0,0,0,0), "after_midstall_rst");

    // Six stall cycles: full counter reads 6, the 2-bit counter holds at 3.
    for (int n = 0; n < 3; n++) begin
      apply(mk(1,1,0,0,0,0,1,1,1,0, 0,0,0,0), $sformatf("sat_ld%0d", n));
      apply(mk(1,1,1,1,0,0,0,0,0,0, 1,0,0,0), $sformatf("sat_s%0d_a", n));
      apply(mk(1,1,1,1,0,0,0,0,0,0, 1,0,0,0), $sformatf("sat_s%0d_b", n));
      apply(mk(1,1,1,1,0,0,0,0,0,0, 0,0,3,0), $sformatf("sat_s%0d_f", n));
    end
    check("sat_full_stall_cnt", int'(bus.stall_cnt), 6);
    check("sat_small_stall_cnt", int'(bus_sat.stall_cnt), 3);

    // Final reset clears counters and all forwarding state.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("final_rst_stall_cnt", int'(bus_sat.stall_cnt), 0);
    check("final_rst_flush_cnt", int'(bus_sat.flush_cnt), 0);
    apply(mk(1,1,1,1,1,1,0,0,0,0, 0,0,0,0), "final_rst_fwd");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
